// File: rtl/cla_pkg.sv
// Shared definitions for the adder residue checker: default width, mod-3 residue type and helpers.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package cla_pkg;

  localparam int ARC_WIDTH_DEF = 8;

  // Residue of a value modulo 3; the encoding 2'b11 never occurs.
  typedef logic [1:0] res3_t;

  localparam res3_t RES3_ZERO = 2'd0;
  localparam res3_t RES3_ONE  = 2'd1;
  localparam res3_t RES3_TWO  = 2'd2;

  // (x + y + c) mod 3 for two residues and a carry bit.
  function automatic res3_t res3_add(input res3_t x, input res3_t y, input logic c);
    logic [2:0] t;
    t = {1'b0, x} + {1'b0, y} + {2'b00, c};
    if (t >= 3'd3) begin
      t = t - 3'd3;
    end
    return t[1:0];
  endfunction

endpackage

// File: rtl/mod3_residue.sv
// Combinational mod-3 residue of a W-bit value by pair folding (even bits weigh 1, odd bits weigh 2).
// Latency: 0 cycles, purely combinational.
// Backpressure: n/a.
module mod3_residue
  import cla_pkg::*;
#(
  parameter int W = ARC_WIDTH_DEF
) (
  input  logic [W-1:0] din,
  output res3_t        res
);

  logic [2:0] acc;

  // Accumulate bit weights (2^i mod 3 alternates 1,2) and keep the running sum reduced below 3.
  always_comb begin
    acc = {1'b0, RES3_ZERO};
    for (int i = 0; i < W; i++) begin
      if (din[i]) begin
        acc = acc + {1'b0, ((i % 2) == 0) ? RES3_ONE : RES3_TWO};
      end
      if (acc >= 3'd3) begin
        acc = acc - 3'd3;
      end
    end
    res = acc[1:0];
  end

endmodule

// File: rtl/add_residue_checker.sv
// Mod-3 residue check of an adder result {cout,s} against its operands a, b, cin; optional saturating
// error counter under ARC_ERR_CNT_EN. Latency: set captured in S1, result in S2 one edge later; 1 set/cycle.
// Backpressure: valid/ready; S1 and S2 hold two sets while out_ready is low, output payload held stable.
module add_residue_checker
  import cla_pkg::*;
#(
  parameter int WIDTH = ARC_WIDTH_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] s,
  input  logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_err,
  output logic             sticky_err,
  input  logic             clr_err,
  output logic [CNT_W-1:0] err_cnt
);

  // Stage 1: captured operands and adder result.
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic [WIDTH:0]   sum_q, sum_d;

  // Stage 2: checked result presented to the consumer.
  logic             out_valid_q, out_valid_d;
  logic [WIDTH:0]   out_sum_q, out_sum_d;
  logic             out_err_q, out_err_d;
  logic             sticky_q, sticky_d;

  logic  s2_adv, s1_load, s2_load, res_err;
  res3_t ra, rb, rs, rab;

  mod3_residue #(.W(WIDTH))   u_res_a (.din(a_q),   .res(ra));
  mod3_residue #(.W(WIDTH))   u_res_b (.din(b_q),   .res(rb));
  mod3_residue #(.W(WIDTH+1)) u_res_s (.din(sum_q), .res(rs));

  // Handshake: S2 can take a set when empty or draining; S1 can take one when empty or moving on.
  always_comb begin
    s2_adv   = !out_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_adv;
    s1_load  = in_valid && in_ready;
    s2_load  = s1_valid_q && s2_adv;
    rab      = res3_add(ra, rb, cin_q);
    res_err  = (rab != rs);
  end

  // Stage 1 next state: capture on acceptance, empty when the set moves on without a refill.
  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    sum_d      = sum_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
      a_d        = a;
      b_d        = b;
      cin_d      = cin;
      sum_d      = {cout, s};
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 next state and sticky flag; an erroneous load beats a coincident clear.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_err_d   = out_err_q;
    sticky_d    = sticky_q;
    if (s2_load) begin
      out_valid_d = 1'b1;
      out_sum_d   = sum_q;
      out_err_d   = res_err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (s2_load && res_err) begin
      sticky_d = 1'b1;
    end else if (clr_err) begin
      sticky_d = 1'b0;
    end
  end

  // Stage 1 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      sum_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      sum_q      <= sum_d;
    end
  end

  // Stage 2 registers and sticky flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_err_q   <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_err_q   <= out_err_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign out_err    = out_err_q;
  assign sticky_err = sticky_q;

`ifdef ARC_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating error count; a clear coinciding with an error restarts the count at one.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (s2_load && res_err) begin
      if (clr_err) begin
        err_cnt_d = CNT_W'(1);
      end else if (err_cnt_q != {CNT_W{1'b1}}) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end else if (clr_err) begin
      err_cnt_d = '0;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_add_residue_checker.sv
// Self-checking bench for add_residue_checker: directed latency, error, backpressure, saturation and
// reset steps plus a randomized stream checked against an arithmetic reference model.
// Counter expectations follow ARC_ERR_CNT_EN; the DUT is built with CNT_W=2.
module tb_add_residue_checker;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
`ifdef ARC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic [WIDTH-1:0] s = '0;
  logic             cout = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH:0]   out_sum;
  logic             out_err;
  logic             sticky_err;
  logic             clr_err = 1'b0;
  logic [CNT_W-1:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [WIDTH:0] sum;
    logic           err;
  } exp_t;

  exp_t q[$];
  exp_t cur_e;
  exp_t ea, eb, ec, ee;
  bit   took;
  int   rnd_errs;
  logic [7:0] ta, tb;
  logic       tc;
  logic [8:0] ts;

  add_residue_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_err(out_err),
    .sticky_err(sticky_err), .clr_err(clr_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the result is consistent iff a+b+cin and {cout,s} agree modulo 3.
  function automatic exp_t mk(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                              input logic [8:0] sv);
    exp_t e;
    e.sum = sv;
    e.err = ((int'(av) + int'(bv) + int'(cv)) % 3) != (int'(sv) % 3);
    return e;
  endfunction

  task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       input logic [8:0] sv);
    a = av; b = bv; cin = cv; {cout, s} = sv; in_valid = 1'b1;
    cur_e = mk(av, bv, cv, sv);
  endtask

  // Correct sum with a one-in-four chance of a single flipped result bit.
  task automatic gen(output logic [7:0] av, output logic [7:0] bv, output logic cv,
                     output logic [8:0] sv);
    av = 8'($urandom);
    bv = 8'($urandom);
    cv = 1'($urandom);
    sv = {1'b0, av} + {1'b0, bv} + {8'b0, cv};
    if ($urandom_range(3) == 0) sv = sv ^ (9'd1 << $urandom_range(8));
  endtask

  // Per-cycle scoreboard step, called mid-cycle after inputs settle.
  task automatic observe();
    chk("rnd_in_ready", in_ready, (q.size() == 2 && !out_ready) ? 0 : 1);
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("rnd_spurious_valid", out_valid, 0);
      end else begin
        chk("rnd_sum", out_sum, q[0].sum);
        chk("rnd_err", out_err, q[0].err);
        if (out_ready) void'(q.pop_front());
      end
    end
    took = in_valid && in_ready;
    if (took) begin
      q.push_back(cur_e);
      if (cur_e.err) rnd_errs++;
    end
  endtask

  initial begin
    // Reset state
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_sticky", sticky_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Clean result and two-edge latency
    drive(8'h3C, 8'h0F, 1'b1, 9'h04C);
    tick();
    in_valid = 1'b0;
    chk("t1_not_yet", out_valid, 0);
    tick();
    chk("t1_valid", out_valid, 1);
    chk("t1_sum", out_sum, 9'h04C);
    chk("t1_err", out_err, 0);
    chk("t1_sticky", sticky_err, 0);

    // Carry-out result
    drive(8'hFF, 8'h01, 1'b0, 9'h100);
    tick();
    in_valid = 1'b0;
    tick();
    chk("t2_valid", out_valid, 1);
    chk("t2_sum", out_sum, 9'h100);
    chk("t2_err", out_err, 0);

    // Injected bit flip, sticky hold, clear
    drive(8'h3C, 8'h0F, 1'b1, 9'h04D);
    tick();
    in_valid = 1'b0;
    tick();
    chk("t3_err", out_err, 1);
    chk("t3_sticky", sticky_err, 1);
    chk("t3_cnt", err_cnt, CNT_EN ? 1 : 0);
    drive(8'h3C, 8'h0F, 1'b1, 9'h04C);
    tick();
    in_valid = 1'b0;
    tick();
    chk("t3_clean_err", out_err, 0);
    chk("t3_sticky_held", sticky_err, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t3_sticky_clr", sticky_err, 0);
    chk("t3_cnt_clr", err_cnt, 0);

    // Backpressure: three sets offered while the consumer stalls
    out_ready = 1'b0;
    gen(ta, tb, tc, ts); drive(ta, tb, tc, ts); ea = cur_e;
    #1;
    chk("bp_rdy_a", in_ready, 1);
    tick();
    gen(ta, tb, tc, ts); drive(ta, tb, tc, ts); eb = cur_e;
    #1;
    chk("bp_rdy_b", in_ready, 1);
    tick();
    gen(ta, tb, tc, ts); drive(ta, tb, tc, ts); ec = cur_e;
    #1;
    chk("bp_rdy_c_blocked", in_ready, 0);
    chk("bp_a_valid", out_valid, 1);
    chk("bp_a_sum", out_sum, ea.sum);
    tick();
    chk("bp_still_blocked", in_ready, 0);
    chk("bp_a_held", out_sum, ea.sum);
    chk("bp_a_err", out_err, ea.err);
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_release", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_b_valid", out_valid, 1);
    chk("bp_b_sum", out_sum, eb.sum);
    chk("bp_b_err", out_err, eb.err);
    tick();
    chk("bp_c_valid", out_valid, 1);
    chk("bp_c_sum", out_sum, ec.sum);
    chk("bp_c_err", out_err, ec.err);
    tick();
    chk("bp_drained", out_valid, 0);

    // Randomized stream against the reference model
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    q.delete();
    rnd_errs = 0;
    took = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!in_valid || took) begin
        if ($urandom_range(3) != 0) begin
          gen(ta, tb, tc, ts);
          drive(ta, tb, tc, ts);
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(2) != 0);
      #1;
      observe();
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      observe();
      tick();
    end
    chk("rnd_drain_empty", q.size(), 0);
    chk("rnd_sticky", sticky_err, (rnd_errs > 0) ? 1 : 0);
    chk("rnd_cnt", err_cnt, CNT_EN ? ((rnd_errs > 3) ? 3 : rnd_errs) : 0);

    // Counter saturation and clear coinciding with an error
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    ee = mk(8'h3C, 8'h0F, 1'b1, 9'h04D);
    drive(8'h3C, 8'h0F, 1'b1, 9'h04D);
    tick(); tick(); tick(); tick();
    in_valid = 1'b0;
    tick();
    chk("sat_last_err", out_err, ee.err);
    tick();
    chk("sat_cnt", err_cnt, CNT_EN ? 3 : 0);
    chk("sat_sticky", sticky_err, 1);
    drive(8'h3C, 8'h0F, 1'b1, 9'h04D);
    tick();
    in_valid = 1'b0;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("sat_clr_err", out_err, 1);
    chk("sat_clr_cnt", err_cnt, CNT_EN ? 1 : 0);
    chk("sat_clr_sticky", sticky_err, 1);
    tick();

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    drive(8'h3C, 8'h0F, 1'b1, 9'h04D);
    tick();
    drive(8'h11, 8'h22, 1'b0, 9'h034);
    tick();
    in_valid = 1'b0;
    chk("ar_full_valid", out_valid, 1);
    chk("ar_full_blocked", in_ready, 0);
    chk("ar_full_sticky", sticky_err, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_sticky", sticky_err, 0);
    chk("ar_cnt", err_cnt, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    chk("ar_no_stale_valid", out_valid, 0);
    chk("ar_no_stale_sum", out_sum, 0);
    chk("ar_no_stale_err", out_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
